// File: rtl/hazard_stall_controller_pkg.sv
// Purpose: shared pipeline-wide types and constants for the hazard/stall controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_stall_controller_pkg;

    // Register-file address width (8 registers).
    localparam int ADDR_W = 3;

    // Register 0 is hard-wired to zero, so it never creates a dependency.
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Purpose: groups the pipeline-side hazard inputs and the stall/flush/freeze controls.
// Latency: n/a (wiring only).
// Backpressure: n/a; master is the pipeline, slave is the controller.
interface hazard_stall_controller_if #(
    parameter int ADDR_W = hazard_stall_controller_pkg::ADDR_W
);
    // Hazard-relevant pipeline state.
    logic [ADDR_W-1:0] IF_ID_Rs;
    logic [ADDR_W-1:0] IF_ID_Rt;
    logic              IF_ID_UsesRs;
    logic              IF_ID_UsesRt;
    logic              IF_ID_IsBranch;
    logic [ADDR_W-1:0] ID_EX_Rd;
    logic              ID_EX_RegWrite;
    logic              ID_EX_MemRead;
    logic [ADDR_W-1:0] EX_MEM_Rd;
    logic              EX_MEM_MemRead;
    logic              BranchTaken;
    logic              Mem_Busy;

    // Pipeline controls.
    logic              PC_Write;
    logic              IF_ID_Write;
    logic              IF_ID_Flush;
    logic              ID_EX_Bubble;
    logic              Pipe_Freeze;
    logic              Stall_Active;
    logic [15:0]       Stall_Cycles;
    logic [15:0]       Freeze_Cycles;

    modport master (
        output IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRs, IF_ID_UsesRt, IF_ID_IsBranch,
               ID_EX_Rd, ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_Rd, EX_MEM_MemRead,
               BranchTaken, Mem_Busy,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze,
               Stall_Active, Stall_Cycles, Freeze_Cycles
    );

    modport slave (
        input  IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRs, IF_ID_UsesRt, IF_ID_IsBranch,
               ID_EX_Rd, ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_Rd, EX_MEM_MemRead,
               BranchTaken, Mem_Busy,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze,
               Stall_Active, Stall_Cycles, Freeze_Cycles
    );

endinterface

// File: rtl/hazard_stall_controller_hazard_detect.sv
// Purpose: load-use and branch-after-load match, producing the required stall length.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is acted on.
module hazard_detect
    import hazard_stall_controller_pkg::*;
#(
    parameter int LU_STALL        = 1,
    parameter int BR_LD_EX_STALL  = 2,
    parameter int BR_LD_MEM_STALL = 1,
    parameter int CNT_W           = 2
) (
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              uses_rs,
    input  logic              uses_rt,
    input  logic              is_branch,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_mem_read,
    output logic [CNT_W-1:0]  req_stall
);

    logic ex_hit;
    logic mem_hit;
    logic lu;
    logic blm;

    // A producer matches if it names a non-zero register the ID instruction reads.
    assign ex_hit  = (ex_rd != ZERO_REG) &&
                     ((uses_rs && (ex_rd == id_rs)) || (uses_rt && (ex_rd == id_rt)));
    assign mem_hit = (mem_rd != ZERO_REG) &&
                     ((uses_rs && (mem_rd == id_rs)) || (uses_rt && (mem_rd == id_rt)));

    assign lu  = ex_mem_read && ex_reg_write && ex_hit;
    assign blm = is_branch && mem_mem_read && mem_hit;

    // Branches compare in ID, so a load one stage ahead costs them an extra cycle.
    always_comb begin
        req_stall = '0;
        if (lu) begin
            req_stall = is_branch ? CNT_W'(BR_LD_EX_STALL) : CNT_W'(LU_STALL);
        end else if (blm) begin
            req_stall = CNT_W'(BR_LD_MEM_STALL);
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Purpose: sequences PC/IF-ID stalls, ID/EX bubbles, fetch flushes and memory-wait freezes.
// Latency: zero; controls are combinational from registered state and current inputs.
// Backpressure: Mem_Busy freezes the whole pipe and outranks stalls, which outrank flushes. Optional perf counters: HAZ_PERF_CNT_EN.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int LU_STALL        = 1,
    parameter int BR_LD_EX_STALL  = 2,
    parameter int BR_LD_MEM_STALL = 1,
    parameter int CNT_W           = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    hazard_stall_controller_if.slave  bus
);

    state_t           state;
    state_t           eff_state;
    logic [CNT_W-1:0] cnt;
    logic             resume_stall;
    logic [CNT_W-1:0] req_stall;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_freeze;
    logic stall_active;

    hazard_detect #(
        .LU_STALL        (LU_STALL),
        .BR_LD_EX_STALL  (BR_LD_EX_STALL),
        .BR_LD_MEM_STALL (BR_LD_MEM_STALL),
        .CNT_W           (CNT_W)
    ) u_detect (
        .id_rs        (bus.IF_ID_Rs),
        .id_rt        (bus.IF_ID_Rt),
        .uses_rs      (bus.IF_ID_UsesRs),
        .uses_rt      (bus.IF_ID_UsesRt),
        .is_branch    (bus.IF_ID_IsBranch),
        .ex_rd        (bus.ID_EX_Rd),
        .ex_reg_write (bus.ID_EX_RegWrite),
        .ex_mem_read  (bus.ID_EX_MemRead),
        .mem_rd       (bus.EX_MEM_Rd),
        .mem_mem_read (bus.EX_MEM_MemRead),
        .req_stall    (req_stall)
    );

    // When the memory wait ends, the interrupted state takes over in that same cycle.
    assign eff_state = ((state == ST_FREEZE) && !bus.Mem_Busy)
                     ? (resume_stall ? ST_STALL : ST_RUN) : state;

    // Control outputs from the effective state; reset forces a free-running pipe.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        stall_active = 1'b0;
        if (!rst) begin
            unique case (eff_state)
                ST_RUN: begin
                    if (bus.Mem_Busy) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        pipe_freeze = 1'b1;
                    end else if (req_stall != '0) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        stall_active = 1'b1;
                    end else begin
                        if_id_flush = bus.BranchTaken;
                    end
                end
                ST_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    stall_active = 1'b1;
                    pipe_freeze  = bus.Mem_Busy;
                    id_ex_bubble = !bus.Mem_Busy;
                end
                ST_FREEZE: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    pipe_freeze  = 1'b1;
                    stall_active = resume_stall;
                end
                default: begin
                    pc_write = 1'b1;
                end
            endcase
        end
    end

    // State, remaining-stall counter and resume flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            cnt          <= '0;
            resume_stall <= 1'b0;
        end else begin
            unique case (eff_state)
                ST_RUN: begin
                    if (bus.Mem_Busy) begin
                        state        <= ST_FREEZE;
                        resume_stall <= 1'b0;
                    end else if (req_stall != '0) begin
                        cnt   <= req_stall - CNT_W'(1);
                        state <= (req_stall > CNT_W'(1)) ? ST_STALL : ST_RUN;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_STALL: begin
                    if (bus.Mem_Busy) begin
                        state        <= ST_FREEZE;
                        resume_stall <= 1'b1;
                    end else if (cnt <= CNT_W'(1)) begin
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else begin
                        cnt   <= cnt - CNT_W'(1);
                        state <= ST_STALL;
                    end
                end
                ST_FREEZE: begin
                    state <= ST_FREEZE;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.PC_Write     = pc_write;
    assign bus.IF_ID_Write  = if_id_write;
    assign bus.IF_ID_Flush  = if_id_flush;
    assign bus.ID_EX_Bubble = id_ex_bubble;
    assign bus.Pipe_Freeze  = pipe_freeze;
    assign bus.Stall_Active = stall_active;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] freeze_cycles;

    // Saturating counts of bubble and freeze cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles  <= '0;
            freeze_cycles <= '0;
        end else begin
            if (id_ex_bubble && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (pipe_freeze && (freeze_cycles != 16'hFFFF)) begin
                freeze_cycles <= freeze_cycles + 16'd1;
            end
        end
    end

    assign bus.Stall_Cycles  = stall_cycles;
    assign bus.Freeze_Cycles = freeze_cycles;
`else
    assign bus.Stall_Cycles  = 16'h0000;
    assign bus.Freeze_Cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Purpose: self-checking bench for hazard_stall_controller (directed scenarios plus random traffic).
// Latency: expected controls are checked every cycle at the falling edge.
// Backpressure: Mem_Busy is driven both in directed freezes and randomly.
module tb_hazard_stall_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_stall_controller_if bus ();

    hazard_stall_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bubbles still owed, plus perf counts.
    int m_pend = 0;
    int m_sc   = 0;
    int m_fc   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Bubbles the ID instruction needs, straight from the hazard rules.
    function automatic int need_model();
        bit hit_ex;
        bit hit_mem;
        hit_ex  = (bus.ID_EX_Rd != 0) &&
                  ((bus.IF_ID_UsesRs && bus.ID_EX_Rd == bus.IF_ID_Rs) ||
                   (bus.IF_ID_UsesRt && bus.ID_EX_Rd == bus.IF_ID_Rt));
        hit_mem = (bus.EX_MEM_Rd != 0) &&
                  ((bus.IF_ID_UsesRs && bus.EX_MEM_Rd == bus.IF_ID_Rs) ||
                   (bus.IF_ID_UsesRt && bus.EX_MEM_Rd == bus.IF_ID_Rt));
        if (bus.ID_EX_MemRead && bus.ID_EX_RegWrite && hit_ex)
            return bus.IF_ID_IsBranch ? 2 : 1;
        if (bus.IF_ID_IsBranch && bus.EX_MEM_MemRead && hit_mem)
            return 1;
        return 0;
    endfunction

    // Compare every output against the model at the falling edge, then step the model.
    task automatic sample();
        bit e_pc, e_ifw, e_fl, e_bub, e_frz, e_sa, busy, stalling;
        int n;
        @(negedge clk);
        busy = bus.Mem_Busy;
        n    = need_model();
        if (rst) begin
            e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_frz = 0; e_sa = 0;
        end else begin
            stalling = (m_pend > 0) || (n > 0);
            e_frz = busy;
            e_bub = !busy && stalling;
            e_pc  = !busy && !stalling;
            e_ifw = e_pc;
            e_fl  = !busy && !stalling && bus.BranchTaken;
            e_sa  = (m_pend > 0) || (!busy && n > 0);
        end
        chk("PC_Write",     16'(bus.PC_Write),     16'(e_pc));
        chk("IF_ID_Write",  16'(bus.IF_ID_Write),  16'(e_ifw));
        chk("IF_ID_Flush",  16'(bus.IF_ID_Flush),  16'(e_fl));
        chk("ID_EX_Bubble", 16'(bus.ID_EX_Bubble), 16'(e_bub));
        chk("Pipe_Freeze",  16'(bus.Pipe_Freeze),  16'(e_frz));
        chk("Stall_Active", 16'(bus.Stall_Active), 16'(e_sa));
`ifdef HAZ_PERF_CNT_EN
        chk("Stall_Cycles",  bus.Stall_Cycles,  16'(m_sc));
        chk("Freeze_Cycles", bus.Freeze_Cycles, 16'(m_fc));
`else
        chk("Stall_Cycles",  bus.Stall_Cycles,  16'h0000);
        chk("Freeze_Cycles", bus.Freeze_Cycles, 16'h0000);
`endif
        if (rst) begin
            m_pend = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (e_bub && m_sc < 65535) m_sc++;
            if (e_frz && m_fc < 65535) m_fc++;
            if (!busy) begin
                if (m_pend > 0) m_pend--;
                else if (n > 0) m_pend = n - 1;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.IF_ID_Rs = '0; bus.IF_ID_Rt = '0;
        bus.IF_ID_UsesRs = 0; bus.IF_ID_UsesRt = 0; bus.IF_ID_IsBranch = 0;
        bus.ID_EX_Rd = '0; bus.ID_EX_RegWrite = 0; bus.ID_EX_MemRead = 0;
        bus.EX_MEM_Rd = '0; bus.EX_MEM_MemRead = 0;
        bus.BranchTaken = 0; bus.Mem_Busy = 0;
    endtask

    task automatic lw_in_ex(input logic [2:0] rd);
        bus.ID_EX_MemRead = 1; bus.ID_EX_RegWrite = 1; bus.ID_EX_Rd = rd;
    endtask

    task automatic id_instr(input logic [2:0] rs, input logic [2:0] rt,
                            input bit urs, input bit urt, input bit br);
        bus.IF_ID_Rs = rs; bus.IF_ID_Rt = rt;
        bus.IF_ID_UsesRs = urs; bus.IF_ID_UsesRt = urt; bus.IF_ID_IsBranch = br;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1;
        sample();
        chk("rst_pc_write", 16'(bus.PC_Write), 16'h1);
        chk("rst_stall_active", 16'(bus.Stall_Active), 16'h0);
        advance();
        rst = 0;
    endtask

    initial begin
        clr_in();
        rst = 1;
        advance();

        // Reset state, then an idle RUN cycle.
        do_reset();
        sample();
        chk("idle_pc_write", 16'(bus.PC_Write), 16'h1);
        chk("idle_bubble", 16'(bus.ID_EX_Bubble), 16'h0);
        advance();

        // lw $3 then add using $3: exactly one bubble.
        lw_in_ex(3); id_instr(3, 1, 1, 1, 0);
        sample();
        chk("lu_bubble", 16'(bus.ID_EX_Bubble), 16'h1);
        chk("lu_pc_write", 16'(bus.PC_Write), 16'h0);
        chk("lu_if_id_write", 16'(bus.IF_ID_Write), 16'h0);
        advance();
        clr_in();
        sample();
        chk("lu_resume_pc", 16'(bus.PC_Write), 16'h1);
        advance();

        // lw $2 then beq using Rt=$2: two bubbles, flush suppressed until RUN.
        lw_in_ex(2); id_instr(5, 2, 1, 1, 1); bus.BranchTaken = 1;
        sample();
        chk("br_bubble1", 16'(bus.ID_EX_Bubble), 16'h1);
        chk("br_active1", 16'(bus.Stall_Active), 16'h1);
        chk("br_flush1", 16'(bus.IF_ID_Flush), 16'h0);
        advance();
        sample();
        chk("br_bubble2", 16'(bus.ID_EX_Bubble), 16'h1);
        chk("br_active2", 16'(bus.Stall_Active), 16'h1);
        chk("br_flush2", 16'(bus.IF_ID_Flush), 16'h0);
        advance();
        bus.ID_EX_MemRead = 0; bus.ID_EX_RegWrite = 0;
        sample();
        chk("br_flush_run", 16'(bus.IF_ID_Flush), 16'h1);
        chk("br_pc_run", 16'(bus.PC_Write), 16'h1);
        advance();

        // Register 0 never matches; ALU producer is forwarded; load in EX/MEM stalls a branch once.
        clr_in(); lw_in_ex(0); id_instr(0, 0, 1, 0, 0);
        sample();
        chk("r0_pc_write", 16'(bus.PC_Write), 16'h1);
        advance();
        clr_in(); bus.ID_EX_RegWrite = 1; bus.ID_EX_Rd = 4; id_instr(4, 0, 1, 0, 1);
        sample();
        chk("alu_fwd_pc", 16'(bus.PC_Write), 16'h1);
        advance();
        clr_in(); bus.EX_MEM_MemRead = 1; bus.EX_MEM_Rd = 5; id_instr(5, 0, 1, 0, 1);
        sample();
        chk("blm_bubble", 16'(bus.ID_EX_Bubble), 16'h1);
        advance();
        clr_in();
        sample();
        chk("blm_done_pc", 16'(bus.PC_Write), 16'h1);
        advance();

        // Freeze for three cycles in the middle of a two-bubble stall.
        lw_in_ex(6); id_instr(6, 0, 1, 0, 1);
        sample();
        advance();
        clr_in(); bus.Mem_Busy = 1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("frz_freeze", 16'(bus.Pipe_Freeze), 16'h1);
            chk("frz_no_bubble", 16'(bus.ID_EX_Bubble), 16'h0);
            advance();
        end
        bus.Mem_Busy = 0;
        sample();
        chk("frz_last_bubble", 16'(bus.ID_EX_Bubble), 16'h1);
        chk("frz_freeze_off", 16'(bus.Pipe_Freeze), 16'h0);
        advance();
        sample();
        chk("frz_run_pc", 16'(bus.PC_Write), 16'h1);
        advance();

        // Reset during the second cycle of a two-bubble stall.
        lw_in_ex(1); id_instr(0, 1, 0, 1, 1);
        sample();
        advance();
        rst = 1;
        sample();
        chk("mid_rst_pc", 16'(bus.PC_Write), 16'h1);
        advance();
        rst = 0; clr_in();
        sample();
        chk("post_rst_pc", 16'(bus.PC_Write), 16'h1);
        chk("post_rst_active", 16'(bus.Stall_Active), 16'h0);
        advance();

        // Perf counters: 2+1 stall cycles followed by a 3-cycle freeze.
        do_reset();
        lw_in_ex(2); id_instr(2, 0, 1, 0, 1);
        sample(); advance();
        clr_in();
        sample(); advance();
        lw_in_ex(7); id_instr(0, 7, 0, 1, 0);
        sample(); advance();
        clr_in(); bus.Mem_Busy = 1;
        for (int i = 0; i < 3; i++) begin
            sample(); advance();
        end
        bus.Mem_Busy = 0;
        sample();
`ifdef HAZ_PERF_CNT_EN
        chk("perf_stall_3", bus.Stall_Cycles, 16'd3);
        chk("perf_freeze_3", bus.Freeze_Cycles, 16'd3);
`else
        chk("perf_stall_off", bus.Stall_Cycles, 16'd0);
        chk("perf_freeze_off", bus.Freeze_Cycles, 16'd0);
`endif
        advance();

        // Random traffic on a narrow register range so matches are frequent.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.IF_ID_Rs       = 3'($urandom_range(0, 3));
            bus.IF_ID_Rt       = 3'($urandom_range(0, 3));
            bus.IF_ID_UsesRs   = 1'($urandom_range(0, 1));
            bus.IF_ID_UsesRt   = 1'($urandom_range(0, 1));
            bus.IF_ID_IsBranch = 1'($urandom_range(0, 1));
            bus.ID_EX_Rd       = 3'($urandom_range(0, 3));
            bus.ID_EX_RegWrite = 1'($urandom_range(0, 1));
            bus.ID_EX_MemRead  = 1'($urandom_range(0, 1));
            bus.EX_MEM_Rd      = 3'($urandom_range(0, 3));
            bus.EX_MEM_MemRead = 1'($urandom_range(0, 1));
            bus.BranchTaken    = 1'($urandom_range(0, 1));
            bus.Mem_Busy       = ($urandom_range(0, 4) == 0);
            sample();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
